// File: rtl/audio_pkg.sv
// Shared constants and reader state encoding for the audio frame collector.
package audio_pkg;

    localparam int AUDIO_DATA_W    = 16;
    localparam int AUDIO_FRAME_LEN = 64;
    localparam int SEQ_W           = 8;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_FETCH  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_t;

endpackage

// File: rtl/audio_frame_collector_if.sv
// Sample input strobe and framed output stream of the audio frame collector.
interface audio_frame_collector_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    import audio_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [ADDR_W-1:0] out_index;
    logic [SEQ_W-1:0]  out_frame_seq;

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, out_last, out_index, out_frame_seq
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, out_last, out_index, out_frame_seq
    );

endinterface

// File: rtl/frame_bank_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
module frame_bank_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/audio_frame_collector.sv
// Packs the sample stream into ping-pong frame banks and replays each full frame.
module audio_frame_collector
    import audio_pkg::*;
#(
    parameter int DATA_W    = AUDIO_DATA_W,
    parameter int FRAME_LEN = AUDIO_FRAME_LEN,
    parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    audio_frame_collector_if.slave  bus,
    output logic                    overflow,
    output logic [SEQ_W-1:0]        dropped_frames
);

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(FRAME_LEN - 1);

    function automatic logic [SEQ_W-1:0] sat_inc(input logic [SEQ_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic              wbank, rbank;
    logic [ADDR_W-1:0] wptr, rptr;
    logic [1:0]        full;
    logic [SEQ_W-1:0]  wseq;
    logic [SEQ_W-1:0]  tag [2];
    rd_state_t         state, state_nxt;
    logic              rd_en, rel;
    logic              wbank_free, wr_en, frame_done;
    logic [DATA_W-1:0] sample_p1;

    // Writes are gated while the target bank still holds an unread frame,
    // so the reader never sees a torn frame.
    assign wbank_free = !full[wbank] || (rel && (rbank == wbank));
    assign wr_en      = bus.in_valid && wbank_free;
    assign frame_done = bus.in_valid && (wptr == PTR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wbank          <= 1'b0;
            wptr           <= '0;
            wseq           <= '0;
            overflow       <= 1'b0;
            dropped_frames <= '0;
        end else if (bus.in_valid) begin
            wptr <= wptr + 1'b1;
            if (frame_done) begin
                wseq <= wseq + 1'b1;
                if (wbank_free) begin
                    wbank      <= ~wbank;
                    tag[wbank] <= wseq;
                end else begin
                    overflow       <= 1'b1;
                    dropped_frames <= sat_inc(dropped_frames);
                end
            end
        end
    end

    // Set after clear: a bank released and refilled on one edge stays full.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            if (rel) full[rbank] <= 1'b0;
            if (frame_done && wbank_free) full[wbank] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RD_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        rel       = 1'b0;
        case (state)
            RD_IDLE:   if (full[rbank]) state_nxt = RD_FETCH;
            RD_FETCH: begin
                rd_en     = 1'b1;
                state_nxt = RD_STREAM;
            end
            RD_STREAM: if (bus.out_ready) begin
                rel       = (rptr == PTR_LAST);
                state_nxt = (rptr == PTR_LAST) ? RD_IDLE : RD_FETCH;
            end
            default:   state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            rbank <= 1'b0;
        end else if (state == RD_STREAM && bus.out_ready) begin
            rptr <= rptr + 1'b1;
            if (rel) rbank <= ~rbank;
        end
    end

    frame_bank_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W + 1)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr ({wbank, wptr}),
        .wr_data (bus.in_data),
        .rd_en   (rd_en),
        .rd_addr ({rbank, rptr}),
        .rd_data (sample_p1)
    );

    // Stream stage: sideband registered alongside the RAM read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid     <= 1'b0;
            bus.out_last      <= 1'b0;
            bus.out_index     <= '0;
            bus.out_frame_seq <= '0;
        end else if (state == RD_FETCH) begin
            bus.out_valid     <= 1'b1;
            bus.out_index     <= rptr;
            bus.out_last      <= (rptr == PTR_LAST);
            bus.out_frame_seq <= tag[rbank];
        end else if (state == RD_STREAM && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    assign bus.out_data = sample_p1;

endmodule

// File: tb/tb_audio_frame_collector.sv
// Directed bench for audio_frame_collector with an 8-sample frame.
module tb_audio_frame_collector;
    import audio_pkg::*;

    localparam int FL = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic overflow;
    logic [7:0] dropped_frames;

    int n_cmp = 0;
    int n_mis = 0;

    logic [15:0] q_data [$];
    logic [2:0]  q_idx  [$];
    logic        q_last [$];
    logic [7:0]  q_seq  [$];

    audio_frame_collector_if #(.DATA_W(16), .ADDR_W(AW)) bus ();

    audio_frame_collector #(
        .DATA_W    (16),
        .FRAME_LEN (FL),
        .ADDR_W    (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave),
        .overflow       (overflow),
        .dropped_frames (dropped_frames)
    );

    always #5 clk = ~clk;

    // Beats are recorded mid-cycle; the handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            q_data.push_back(bus.out_data);
            q_idx.push_back(bus.out_index);
            q_last.push_back(bus.out_last);
            q_seq.push_back(bus.out_frame_seq);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_beats();
        q_data.delete();
        q_idx.delete();
        q_last.delete();
        q_seq.delete();
    endtask

    task automatic write_sample(input logic [15:0] d);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic write_frame(input logic [15:0] base);
        for (int i = 0; i < FL; i++) write_sample(base + 16'(i));
    endtask

    task automatic wait_beats(input string tag, input int n);
        int t = 0;
        while (q_data.size() < n && t < 1000) begin
            tick();
            t++;
        end
        chk({tag, "_beats"}, q_data.size(), n);
    endtask

    task automatic wait_at(input string tag, input logic [2:0] idx, input logic [7:0] seq);
        int t = 0;
        while (!(bus.out_valid && bus.out_index == idx && bus.out_frame_seq == seq) && t < 500) begin
            tick();
            t++;
        end
        chk({tag, "_reach"}, (t < 500) ? 1 : 0, 1);
    endtask

    task automatic check_frame(input string tag, input int first, input logic [15:0] base,
                               input logic [7:0] seq);
        for (int i = 0; i < FL; i++) begin
            chk($sformatf("%s_data%0d", tag, i), q_data[first+i], base + 16'(i));
            chk($sformatf("%s_idx%0d", tag, i), q_idx[first+i], i);
            chk($sformatf("%s_last%0d", tag, i), q_last[first+i], (i == FL - 1) ? 1 : 0);
            chk($sformatf("%s_seq%0d", tag, i), q_seq[first+i], seq);
        end
    endtask

    initial begin
        logic [15:0] held_data;
        int bad;

        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_index", bus.out_index, 0);
        chk("rst_seq", bus.out_frame_seq, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", dropped_frames, 0);

        // Basic frame and first-beat latency
        clear_beats();
        bus.out_ready = 1'b1;
        for (int i = 0; i < FL; i++) write_sample(16'h0100 + 16'(i));
        chk("lat_e0", bus.out_valid, 0);
        tick();
        chk("lat_e1", bus.out_valid, 0);
        tick();
        chk("lat_e2", bus.out_valid, 1);
        chk("lat_e2_data", bus.out_data, 16'h0100);
        wait_beats("basic", 8);
        check_frame("basic", 0, 16'h0100, 8'd0);

        // Backpressure mid-frame
        clear_beats();
        write_frame(16'h0200);
        wait_at("bp", 3'd4, 8'd1);
        bus.out_ready = 1'b0;
        held_data = bus.out_data;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.out_valid || bus.out_data != held_data || bus.out_index != 3'd4) bad++;
        end
        chk("bp_unstable", bad, 0);
        chk("bp_held_data", held_data, 16'h0204);
        bus.out_ready = 1'b1;
        wait_beats("bp", 8);
        repeat (10) tick();
        chk("bp_no_dup", q_data.size(), 8);
        check_frame("bp", 0, 16'h0200, 8'd1);

        // Overflow: two frames held, third dropped
        do_reset();
        clear_beats();
        bus.out_ready = 1'b0;
        write_frame(16'h0300);
        write_frame(16'h0400);
        write_frame(16'h0500);
        repeat (3) tick();
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", dropped_frames, 1);
        chk("ovf_hold_valid", bus.out_valid, 1);
        chk("ovf_hold_seq", bus.out_frame_seq, 0);
        bus.out_ready = 1'b1;
        wait_beats("ovf", 16);
        check_frame("ovf_f0", 0, 16'h0300, 8'd0);
        check_frame("ovf_f1", 8, 16'h0400, 8'd1);
        write_frame(16'h0600);
        wait_beats("ovf3", 24);
        check_frame("ovf_f3", 16, 16'h0600, 8'd3);
        chk("ovf_sticky", overflow, 1);

        // Reset mid-stream discards everything
        clear_beats();
        write_frame(16'h0900);
        wait_at("mrst", 3'd4, 8'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", bus.out_valid, 0);
        chk("mrst_ovf", overflow, 0);
        chk("mrst_drop", dropped_frames, 0);
        chk("mrst_seq", bus.out_frame_seq, 0);
        chk("mrst_index", bus.out_index, 0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid) bad++;
        end
        chk("mrst_quiet", bad, 0);
        clear_beats();
        write_frame(16'h0A00);
        wait_beats("mrst", 8);
        check_frame("mrst", 0, 16'h0A00, 8'd0);

        // Release and completion on the same edge
        do_reset();
        clear_beats();
        bus.out_ready = 1'b0;
        write_frame(16'h0700);
        write_frame(16'h0800);
        for (int i = 0; i < FL - 1; i++) write_sample(16'h0B00 + 16'(i));
        bus.out_ready = 1'b1;
        wait_at("same", 3'd7, 8'd0);
        chk("same_last_pending", bus.out_last, 1);
        write_sample(16'h0B07);
        chk("same_ovf", overflow, 0);
        chk("same_drop", dropped_frames, 0);
        wait_beats("same", 24);
        check_frame("same_f0", 0, 16'h0700, 8'd0);
        check_frame("same_f1", 8, 16'h0800, 8'd1);
        chk("same_f2_idx0", q_idx[16], 0);
        chk("same_f2_seq0", q_seq[16], 2);
        chk("same_f2_seq7", q_seq[23], 2);
        chk("same_f2_last", q_last[23], 1);
        chk("same_f2_data7", q_data[23], 16'h0B07);

        // Drop counter saturation
        do_reset();
        bus.out_ready = 1'b0;
        for (int f = 0; f < 302; f++) write_frame(16'hC000);
        tick();
        chk("sat_drop", dropped_frames, 255);
        chk("sat_ovf", overflow, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
